id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Pipeline register between decode (ID) and execute (EX) of the five-stage RISC-V core. Captures one decoded instruction per handshake and presents ALU operands `ex_a`/`ex_b` and `ex_alu_op` to the EX-stage ALU. Resolves RAW hazards by forwarding from EX/MEM and MEM/WB, and inserts a single bubble on load-use.

## Interface
Parameters:
- XLEN, 32, datapath width
- RA_W, 5, register address width

Ports (clock/reset first):
- clk  in  1  core clock; all state on rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  branch/jump redirect; kills capture and current content
- id_valid  in  1  ID holds an instruction
- id_ready  out  1  stage accepts this cycle
- id_pc  in  XLEN  instruction PC
- id_rs1_addr, id_rs2_addr  in  RA_W  source registers
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data; write-first regfile
- id_imm  in  XLEN  sign-extended immediate
- id_alu_op  in  3  ALU opcode: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 mul, 6 mulh
- id_src_a_sel  in  1  0 = rs1, 1 = pc
- id_src_b_sel  in  1  0 = rs2, 1 = imm
- id_rd_addr  in  RA_W  destination
- id_rd_we  in  1  writes rd
- id_mem_rd  in  1  load instruction
- ex_valid  out  1  EX content valid
- ex_ready  in  1  EX accepts; low only when the whole backend is frozen
- ex_a, ex_b  out  XLEN  final ALU operands, forwarding applied
- ex_store_data  out  XLEN  forwarded rs2 value
- ex_alu_op  out  3  registered opcode
- ex_pc  out  XLEN  registered PC
- ex_rd_addr  out  RA_W; ex_rd_we  out  1; ex_mem_rd  out  1
- exm_rd_we  in  1; exm_rd_addr  in  RA_W; exm_result  in  XLEN  EX/MEM ALU result
- wb_rd_we  in  1; wb_rd_addr  in  RA_W; wb_data  in  XLEN  MEM/WB writeback value

## Operation
- Capture when `id_valid && id_ready && !flush`. Latch all id_* fields and set `ex_valid=1`.
- Otherwise, if `ex_ready` or `flush`, clear `ex_valid`. Stored fields may be left stale.
- `id_ready = (!ex_valid || ex_ready) && !hazard_stall && !flush`.
- Load-use: `hazard_stall` = `ex_valid && ex_mem_rd && ex_rd_we && ex_rd_addr!=0 && (ex_rd_addr==id_rs1_addr || ex_rd_addr==id_rs2_addr)`. The following cycle `ex_valid=0` (bubble); then ID captures normally.
- Forwarding is combinational on the stored rs values. Per operand: EX/MEM match (`exm_rd_we`, addr!=0, addr equal) → `exm_result`. Else MEM/WB match → `wb_data`. Else stored data. EX/MEM has priority.
- Register 0 never matches anywhere.
- `ex_a` = pc if src_a_sel else fwd rs1. `ex_b` = imm if src_b_sel else fwd rs2. `ex_store_data` = fwd rs2 always.
- `flush` and `rst` are valid at the same edge; `rst` dominates.

## Timing
- Latency ID→EX is 1 cycle; throughput 1 instr/cycle without hazard.
- Load-use costs exactly 1 bubble.
- Reset: `ex_valid`, `ex_a`, `ex_b`, `ex_store_data`, `ex_pc`, `ex_alu_op`, `ex_rd_addr`, `ex_rd_we`, `ex_mem_rd` all 0. `id_ready=1` the first cycle after `rst` deasserts.
- While `ex_ready=0`: all registered outputs hold. The backend keeps forward sources stable.
- Reset mid-stall discards the held instruction.

## Configuration
- `ID_EX_FWD_EN` defined: forwarding as above.
- `ID_EX_FWD_EN` undefined: forwarding muxes removed; outputs use stored data only. `hazard_stall` becomes any nonzero rs1/rs2 match against a valid ID/EX rd (`ex_rd_we`) or EX/MEM rd (`exm_rd_we`). WB is covered by the write-first regfile.
- Without the macro, a distance-1 RAW costs 2 bubbles and a distance-2 RAW costs 1.

## Structure
- Shared package `riscv_pkg`:
  - ALU opcode constants `ALU_ADD`..`ALU_MULH` (0–6)
  - `SRC_A_RS1/SRC_A_PC`, `SRC_B_RS2/SRC_B_IMM`
  - XLEN, RA_W defaults
- Sub-module `hazard_unit`: combinational match logic, forward select, and `hazard_stall`. Its internals are selected by `ID_EX_FWD_EN`.

## Test plan
- add x1=5+11 (`exm_result=0x10`, `exm_rd_addr=1`), then sub x4,x1,x5 with stale rs1 0 → `ex_a=0x10`. Same with `wb_rd_addr=1`, `wb_data=0x20`, also matching → `ex_a=0x10` (EX/MEM priority).
- lw x1 in EX, ID add x2,x1,x1 → `id_ready=0` one cycle, `ex_valid=0` one cycle. Next cycle `ex_a=ex_b=wb_data=0xCAFE`.
- `exm_rd_we=1`, `exm_rd_addr=0`, `exm_result=0xDEAD`, rs1=x0 with data 0 → `ex_a=0`.
- flush with `id_valid=1` → next cycle `ex_valid=0`, nothing captured. flush with `rst` → reset values.
- `ex_ready=0` for 3 cycles with valid content → outputs bit-stable, `id_ready=0`. `rst` asserted mid-hold → all outputs 0.
- Macro undefined: add x1; then add x2,x1,x3 back-to-back → 2 bubbles, then `ex_a` equals regfile value.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V core constants: ALU opcodes, operand-source selects, datapath defaults.
// No logic; pure declarations.
// No flow control.
package riscv_pkg;

    localparam int DEF_XLEN = 32;
    localparam int DEF_RA_W = 5;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_AND  = 3'd2;
    localparam logic [2:0] ALU_OR   = 3'd3;
    localparam logic [2:0] ALU_XOR  = 3'd4;
    localparam logic [2:0] ALU_MUL  = 3'd5;
    localparam logic [2:0] ALU_MULH = 3'd6;

    localparam logic SRC_A_RS1 = 1'b0;
    localparam logic SRC_A_PC  = 1'b1;
    localparam logic SRC_B_RS2 = 1'b0;
    localparam logic SRC_B_IMM = 1'b1;

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle of the ID-side handshake, the EX-side outputs and the forwarding sources.
// No logic; slave = the ID/EX stage, master = the surrounding pipeline.
// id_valid/id_ready handshake on the ID side, ex_valid/ex_ready on the EX side.
interface id_ex_stage_if #(
    parameter int XLEN = riscv_pkg::DEF_XLEN,
    parameter int RA_W = riscv_pkg::DEF_RA_W
);
    logic            flush;
    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_pc;
    logic [RA_W-1:0] id_rs1_addr;
    logic [RA_W-1:0] id_rs2_addr;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [XLEN-1:0] id_imm;
    logic [2:0]      id_alu_op;
    logic            id_src_a_sel;
    logic            id_src_b_sel;
    logic [RA_W-1:0] id_rd_addr;
    logic            id_rd_we;
    logic            id_mem_rd;
    logic            ex_valid;
    logic            ex_ready;
    logic [XLEN-1:0] ex_a;
    logic [XLEN-1:0] ex_b;
    logic [XLEN-1:0] ex_store_data;
    logic [2:0]      ex_alu_op;
    logic [XLEN-1:0] ex_pc;
    logic [RA_W-1:0] ex_rd_addr;
    logic            ex_rd_we;
    logic            ex_mem_rd;
    logic            exm_rd_we;
    logic [RA_W-1:0] exm_rd_addr;
    logic [XLEN-1:0] exm_result;
    logic            wb_rd_we;
    logic [RA_W-1:0] wb_rd_addr;
    logic [XLEN-1:0] wb_data;

    modport slave (
        input  flush, id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data,
               id_imm, id_alu_op, id_src_a_sel, id_src_b_sel, id_rd_addr, id_rd_we, id_mem_rd,
               ex_ready, exm_rd_we, exm_rd_addr, exm_result, wb_rd_we, wb_rd_addr, wb_data,
        output id_ready, ex_valid, ex_a, ex_b, ex_store_data, ex_alu_op, ex_pc,
               ex_rd_addr, ex_rd_we, ex_mem_rd
    );

    modport master (
        output flush, id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data,
               id_imm, id_alu_op, id_src_a_sel, id_src_b_sel, id_rd_addr, id_rd_we, id_mem_rd,
               ex_ready, exm_rd_we, exm_rd_addr, exm_result, wb_rd_we, wb_rd_addr, wb_data,
        input  id_ready, ex_valid, ex_a, ex_b, ex_store_data, ex_alu_op, ex_pc,
               ex_rd_addr, ex_rd_we, ex_mem_rd
    );
endinterface

// File: rtl/hazard_unit.sv
// RAW hazard detection and operand forwarding for the ID/EX stage; ID_EX_FWD_EN enables bypass.
// Purely combinational, zero latency.
// Produces hazard_stall, which the stage uses to hold ID; no state of its own.
module hazard_unit #(
    parameter int XLEN = riscv_pkg::DEF_XLEN,
    parameter int RA_W = riscv_pkg::DEF_RA_W
) (
    input  logic            ex_valid,
    input  logic            ex_mem_rd,
    input  logic            ex_rd_we,
    input  logic [RA_W-1:0] ex_rd_addr,
    input  logic [RA_W-1:0] id_rs1_addr,
    input  logic [RA_W-1:0] id_rs2_addr,
    input  logic [RA_W-1:0] st_rs1_addr,
    input  logic [RA_W-1:0] st_rs2_addr,
    input  logic [XLEN-1:0] st_rs1_data,
    input  logic [XLEN-1:0] st_rs2_data,
    input  logic            exm_rd_we,
    input  logic [RA_W-1:0] exm_rd_addr,
    input  logic [XLEN-1:0] exm_result,
    input  logic            wb_rd_we,
    input  logic [RA_W-1:0] wb_rd_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] rs1_fwd,
    output logic [XLEN-1:0] rs2_fwd,
    output logic            hazard_stall
);

    // x0 is hardwired zero, so a write to it never produces a dependency.
    function automatic logic hit(input logic we, input logic [RA_W-1:0] rd, input logic [RA_W-1:0] rs);
        return we && (rd != '0) && (rd == rs);
    endfunction

    logic ex_hits_id;
    assign ex_hits_id = hit(ex_valid && ex_rd_we, ex_rd_addr, id_rs1_addr) ||
                        hit(ex_valid && ex_rd_we, ex_rd_addr, id_rs2_addr);

`ifdef ID_EX_FWD_EN
    // Only a load in EX cannot be bypassed: its data arrives one stage too late.
    assign hazard_stall = ex_hits_id && ex_mem_rd;

    // Youngest producer wins: EX/MEM overrides MEM/WB, which overrides the stored read.
    always_comb begin
        rs1_fwd = st_rs1_data;
        rs2_fwd = st_rs2_data;
        if (hit(wb_rd_we, wb_rd_addr, st_rs1_addr))   rs1_fwd = wb_data;
        if (hit(exm_rd_we, exm_rd_addr, st_rs1_addr)) rs1_fwd = exm_result;
        if (hit(wb_rd_we, wb_rd_addr, st_rs2_addr))   rs2_fwd = wb_data;
        if (hit(exm_rd_we, exm_rd_addr, st_rs2_addr)) rs2_fwd = exm_result;
    end
`else
    // Without bypass, wait until the producer reaches WB; the write-first regfile covers WB.
    assign hazard_stall = ex_hits_id ||
                          hit(exm_rd_we, exm_rd_addr, id_rs1_addr) ||
                          hit(exm_rd_we, exm_rd_addr, id_rs2_addr);
    assign rs1_fwd = st_rs1_data;
    assign rs2_fwd = st_rs2_data;

    logic unused_fwd;
    assign unused_fwd = ^{ex_mem_rd, st_rs1_addr, st_rs2_addr, exm_result,
                          wb_rd_we, wb_rd_addr, wb_data};
`endif

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register presenting forwarded ALU operands; bypass enabled by ID_EX_FWD_EN.
// Latency 1 cycle ID->EX, 1 instr/cycle; load-use (or unbypassed RAW) inserts bubbles.
// Holds everything while ex_ready=0; id_ready drops on stall, flush or a blocked full slot.
module id_ex_stage #(
    parameter int XLEN = riscv_pkg::DEF_XLEN,
    parameter int RA_W = riscv_pkg::DEF_RA_W
) (
    input  logic          clk,
    input  logic          rst,
    id_ex_stage_if.slave  bus
);
    import riscv_pkg::*;

    logic            vld_q;
    logic [XLEN-1:0] pc_q;
    logic [RA_W-1:0] rs1_addr_q;
    logic [RA_W-1:0] rs2_addr_q;
    logic [XLEN-1:0] rs1_data_q;
    logic [XLEN-1:0] rs2_data_q;
    logic [XLEN-1:0] imm_q;
    logic [2:0]      alu_op_q;
    logic            src_a_sel_q;
    logic            src_b_sel_q;
    logic [RA_W-1:0] rd_addr_q;
    logic            rd_we_q;
    logic            mem_rd_q;

    logic            hazard_stall;
    logic            capture;
    logic [XLEN-1:0] rs1_fwd;
    logic [XLEN-1:0] rs2_fwd;

    hazard_unit #(.XLEN(XLEN), .RA_W(RA_W)) u_hazard (
        .ex_valid     (vld_q),
        .ex_mem_rd    (mem_rd_q),
        .ex_rd_we     (rd_we_q),
        .ex_rd_addr   (rd_addr_q),
        .id_rs1_addr  (bus.id_rs1_addr),
        .id_rs2_addr  (bus.id_rs2_addr),
        .st_rs1_addr  (rs1_addr_q),
        .st_rs2_addr  (rs2_addr_q),
        .st_rs1_data  (rs1_data_q),
        .st_rs2_data  (rs2_data_q),
        .exm_rd_we    (bus.exm_rd_we),
        .exm_rd_addr  (bus.exm_rd_addr),
        .exm_result   (bus.exm_result),
        .wb_rd_we     (bus.wb_rd_we),
        .wb_rd_addr   (bus.wb_rd_addr),
        .wb_data      (bus.wb_data),
        .rs1_fwd      (rs1_fwd),
        .rs2_fwd      (rs2_fwd),
        .hazard_stall (hazard_stall)
    );

    assign bus.id_ready = (!vld_q || bus.ex_ready) && !hazard_stall && !bus.flush;
    assign capture      = bus.id_valid && bus.id_ready && !bus.flush;

    // Slot update: reset dominates, then capture, then drain on EX accept or flush; else hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q       <= 1'b0;
            pc_q        <= '0;
            rs1_addr_q  <= '0;
            rs2_addr_q  <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            alu_op_q    <= '0;
            src_a_sel_q <= 1'b0;
            src_b_sel_q <= 1'b0;
            rd_addr_q   <= '0;
            rd_we_q     <= 1'b0;
            mem_rd_q    <= 1'b0;
        end else if (capture) begin
            vld_q       <= 1'b1;
            pc_q        <= bus.id_pc;
            rs1_addr_q  <= bus.id_rs1_addr;
            rs2_addr_q  <= bus.id_rs2_addr;
            rs1_data_q  <= bus.id_rs1_data;
            rs2_data_q  <= bus.id_rs2_data;
            imm_q       <= bus.id_imm;
            alu_op_q    <= bus.id_alu_op;
            src_a_sel_q <= bus.id_src_a_sel;
            src_b_sel_q <= bus.id_src_b_sel;
            rd_addr_q   <= bus.id_rd_addr;
            rd_we_q     <= bus.id_rd_we;
            mem_rd_q    <= bus.id_mem_rd;
        end else if (bus.ex_ready || bus.flush) begin
            vld_q <= 1'b0;
        end
    end

    assign bus.ex_valid      = vld_q;
    assign bus.ex_a          = (src_a_sel_q == SRC_A_PC)  ? pc_q  : rs1_fwd;
    assign bus.ex_b          = (src_b_sel_q == SRC_B_IMM) ? imm_q : rs2_fwd;
    assign bus.ex_store_data = rs2_fwd;
    assign bus.ex_alu_op     = alu_op_q;
    assign bus.ex_pc         = pc_q;
    assign bus.ex_rd_addr    = rd_addr_q;
    assign bus.ex_rd_we      = rd_we_q;
    assign bus.ex_mem_rd     = mem_rd_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed hazard/flush/hold scenarios plus random traffic.
// Reference model: one-instruction slot plus a producer-priority operand lookup.
// Works with ID_EX_FWD_EN defined or not.
module tb_id_ex_stage;
    import riscv_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_ex_stage_if #(.XLEN(DEF_XLEN), .RA_W(DEF_RA_W)) bus ();

    id_ex_stage #(.XLEN(DEF_XLEN), .RA_W(DEF_RA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic [2:0]  op;
        logic        sa;
        logic        sb;
        logic [4:0]  rd;
        logic        we;
        logic        mrd;
    } instr_t;

    int errors = 0;
    int checks = 0;

    instr_t slot;      // what the EX slot holds (last captured instruction)
    bit     occupied;  // slot holds a live instruction
    bit     fresh;     // nothing captured since reset: fields are defined as zero
    instr_t id_cur;    // instruction currently offered by ID

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic instr_t mk(input logic [31:0] pc, input logic [2:0] op, input logic [4:0] rd,
                                  input logic [4:0] rs1, input logic [4:0] rs2,
                                  input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                                  input logic sa, input logic sb, input logic we, input logic mrd);
        instr_t i;
        i.pc = pc; i.op = op; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2; i.d1 = d1; i.d2 = d2;
        i.imm = imm; i.sa = sa; i.sb = sb; i.we = we; i.mrd = mrd;
        return i;
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        i.pc  = $urandom & 32'hFFFF_FFFC;
        i.rs1 = 5'($urandom_range(0, 3));
        i.rs2 = 5'($urandom_range(0, 3));
        i.d1  = $urandom;
        i.d2  = $urandom;
        i.imm = $urandom;
        i.op  = 3'($urandom_range(0, 6));
        i.sa  = ($urandom_range(0, 3) == 0);
        i.sb  = ($urandom_range(0, 2) == 0);
        i.rd  = 5'($urandom_range(0, 3));
        i.we  = ($urandom_range(0, 3) != 0);
        i.mrd = ($urandom_range(0, 3) == 0);
        return i;
    endfunction

    task automatic drive(input bit v, input instr_t i);
        id_cur           = i;
        bus.id_valid     = v;
        bus.id_pc        = i.pc;
        bus.id_rs1_addr  = i.rs1;
        bus.id_rs2_addr  = i.rs2;
        bus.id_rs1_data  = i.d1;
        bus.id_rs2_data  = i.d2;
        bus.id_imm       = i.imm;
        bus.id_alu_op    = i.op;
        bus.id_src_a_sel = i.sa;
        bus.id_src_b_sel = i.sb;
        bus.id_rd_addr   = i.rd;
        bus.id_rd_we     = i.we;
        bus.id_mem_rd    = i.mrd;
    endtask

    task automatic backend(input bit ew, input logic [4:0] ea, input logic [31:0] er,
                           input bit ww, input logic [4:0] wa, input logic [31:0] wd);
        bus.exm_rd_we = ew; bus.exm_rd_addr = ea; bus.exm_result = er;
        bus.wb_rd_we  = ww; bus.wb_rd_addr  = wa; bus.wb_data    = wd;
    endtask

    // Value of register a as EX should see it: the newest in-flight producer, else the ID read.
    function automatic logic [31:0] operand(input logic [4:0] a, input logic [31:0] stored);
        logic [31:0] v;
        v = stored;
`ifdef ID_EX_FWD_EN
        if (a != 0 && bus.wb_rd_we  && bus.wb_rd_addr  == a) v = bus.wb_data;
        if (a != 0 && bus.exm_rd_we && bus.exm_rd_addr == a) v = bus.exm_result;
`endif
        return v;
    endfunction

    // Does the instruction in ID read a register whose value is not yet obtainable?
    function automatic bit model_stall();
        logic [4:0] pend[$];
`ifdef ID_EX_FWD_EN
        if (occupied && slot.we && slot.mrd) pend.push_back(slot.rd);
`else
        if (occupied && slot.we) pend.push_back(slot.rd);
        if (bus.exm_rd_we) pend.push_back(bus.exm_rd_addr);
`endif
        foreach (pend[k])
            if (pend[k] != 0 && (pend[k] == bus.id_rs1_addr || pend[k] == bus.id_rs2_addr)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit exp_ready();
        return (!occupied || bus.ex_ready) && !model_stall() && !bus.flush;
    endfunction

    task automatic sample();
        #1;
        check("ex_valid", bus.ex_valid, occupied);
        check("id_ready", bus.id_ready, exp_ready());
        if (occupied || fresh) begin
            check("ex_pc", bus.ex_pc, slot.pc);
            check("ex_alu_op", bus.ex_alu_op, slot.op);
            check("ex_rd_addr", bus.ex_rd_addr, slot.rd);
            check("ex_rd_we", bus.ex_rd_we, slot.we);
            check("ex_mem_rd", bus.ex_mem_rd, slot.mrd);
            check("ex_a", bus.ex_a, slot.sa ? slot.pc : operand(slot.rs1, slot.d1));
            check("ex_b", bus.ex_b, slot.sb ? slot.imm : operand(slot.rs2, slot.d2));
            check("ex_store_data", bus.ex_store_data, operand(slot.rs2, slot.d2));
        end
    endtask

    task automatic tick();
        bit rdy;
        rdy = exp_ready();
        @(posedge clk);
        if (rst) begin
            occupied = 0; fresh = 1; slot = '0;
        end else if (bus.id_valid && rdy) begin
            slot = id_cur; occupied = 1; fresh = 0;
        end else if (bus.ex_ready || bus.flush) begin
            occupied = 0;
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        bus.flush = 1'b0;
        bus.ex_ready = 1'b1;
        drive(0, '0);
        backend(0, 0, 0, 0, 0, 0);
        occupied = 0; fresh = 1; slot = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        sample();
        tick();
        rst = 1'b0;
        sample();
        check("rst_id_ready", bus.id_ready, 1);
        check("rst_ex_a", bus.ex_a, 0);

        // add x1, x2, x3 (5 + 11)
        drive(1, mk(32'h100, ALU_ADD, 1, 2, 3, 5, 11, 0, 0, 0, 1, 0));
        sample(); tick();
`ifdef ID_EX_FWD_EN
        // sub x4, x1, x5 with a stale x1 read of 0
        drive(1, mk(32'h104, ALU_SUB, 4, 1, 5, 0, 7, 0, 0, 0, 1, 0));
        sample(); check("raw_ready", bus.id_ready, 1); tick();
        drive(0, '0);
        backend(1, 1, 32'h10, 0, 0, 0);
        sample(); check("fwd_exm", bus.ex_a, 32'h10);
        backend(1, 1, 32'h10, 1, 1, 32'h20);
        sample(); check("fwd_prio", bus.ex_a, 32'h10);
        backend(0, 0, 0, 1, 1, 32'h20);
        sample(); check("fwd_wb", bus.ex_a, 32'h20);
        tick();
        backend(0, 0, 0, 0, 0, 0);
        // lw x1, 4(x2) then add x2, x1, x1
        drive(1, mk(32'h110, ALU_ADD, 1, 2, 0, 0, 0, 4, 0, 1, 1, 1));
        sample(); tick();
        drive(1, mk(32'h114, ALU_ADD, 2, 1, 1, 0, 0, 0, 0, 0, 1, 0));
        sample(); check("lu_stall", bus.id_ready, 0); tick();
        sample(); check("lu_bubble", bus.ex_valid, 0); check("lu_ready", bus.id_ready, 1); tick();
        drive(0, '0);
        backend(0, 0, 0, 1, 1, 32'hCAFE);
        sample();
        check("lu_valid", bus.ex_valid, 1);
        check("lu_a", bus.ex_a, 32'hCAFE);
        check("lu_b", bus.ex_b, 32'hCAFE);
        tick();
`else
        // add x2, x1, x3 back-to-back: two bubbles before it enters EX
        drive(1, mk(32'h104, ALU_ADD, 2, 1, 3, 0, 11, 0, 0, 0, 1, 0));
        sample(); check("raw_stall", bus.id_ready, 0); tick();
        backend(1, 1, 32'h10, 0, 0, 0);
        sample(); check("bubble1", bus.ex_valid, 0); check("bubble1_ready", bus.id_ready, 0); tick();
        backend(0, 0, 0, 1, 1, 32'h10);
        drive(1, mk(32'h104, ALU_ADD, 2, 1, 3, 32'h10, 11, 0, 0, 0, 1, 0));
        sample(); check("bubble2", bus.ex_valid, 0); check("bubble2_ready", bus.id_ready, 1); tick();
        drive(0, '0);
        backend(0, 0, 0, 0, 0, 0);
        sample(); check("raw_valid", bus.ex_valid, 1); check("raw_regfile", bus.ex_a, 32'h10); tick();
`endif
        // x0 never forwards
        backend(1, 0, 32'hDEAD, 1, 0, 32'hBEEF);
        drive(1, mk(32'h200, ALU_ADD, 3, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        sample(); tick();
        drive(0, '0);
        sample();
        check("x0_a", bus.ex_a, 0);
        check("x0_b", bus.ex_b, 0);
        check("x0_store", bus.ex_store_data, 0);
        tick();
        backend(0, 0, 0, 0, 0, 0);

        // flush kills capture
        drive(1, mk(32'h300, ALU_XOR, 5, 6, 7, 1, 2, 0, 0, 0, 1, 0));
        bus.flush = 1'b1;
        sample(); check("flush_ready", bus.id_ready, 0); tick();
        bus.flush = 1'b0;
        drive(0, '0);
        sample(); check("flush_valid", bus.ex_valid, 0); tick();
        // flush together with reset: reset values
        drive(1, mk(32'h310, ALU_AND, 5, 6, 7, 3, 4, 0, 1, 0, 1, 0));
        sample(); tick();
        rst = 1'b1; bus.flush = 1'b1;
        drive(1, mk(32'h320, ALU_OR, 5, 6, 7, 3, 4, 0, 0, 0, 1, 0));
        sample(); tick();
        rst = 1'b0; bus.flush = 1'b0;
        drive(0, '0);
        sample();
        check("flrst_valid", bus.ex_valid, 0);
        check("flrst_pc", bus.ex_pc, 0);
        check("flrst_a", bus.ex_a, 0);
        tick();

        // backend frozen for 3 cycles, then reset mid-hold
        drive(1, mk(32'h400, ALU_OR, 6, 2, 3, 32'hF0, 32'h0F, 0, 0, 0, 1, 0));
        sample(); tick();
        bus.ex_ready = 1'b0;
        drive(1, mk(32'h404, ALU_MUL, 7, 8, 9, 1, 1, 0, 0, 0, 1, 0));
        for (int i = 0; i < 3; i++) begin
            sample();
            check("hold_valid", bus.ex_valid, 1);
            check("hold_pc", bus.ex_pc, 32'h400);
            check("hold_a", bus.ex_a, 32'hF0);
            check("hold_ready", bus.id_ready, 0);
            tick();
        end
        rst = 1'b1;
        sample(); tick();
        rst = 1'b0;
        drive(0, '0);
        sample();
        check("rsthold_valid", bus.ex_valid, 0);
        check("rsthold_pc", bus.ex_pc, 0);
        check("rsthold_a", bus.ex_a, 0);
        bus.ex_ready = 1'b1;
        tick();

        // random traffic
        for (int n = 0; n < 600; n++) begin
            rst          = ($urandom_range(0, 63) == 0);
            bus.flush    = ($urandom_range(0, 7) == 0);
            bus.ex_ready = ($urandom_range(0, 3) != 0);
            drive($urandom_range(0, 3) != 0, rand_instr());
            backend($urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)), $urandom,
                    $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)), $urandom);
            sample();
            tick();
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
